// File: rtl/sreg_mc_delay.sv
// Multi-channel programmable delay line over a shared distributed-RAM ring,
// with FILL/RUN warm-up tracking. Optional tap port enabled by SREG_MC_TAP_EN.
module sreg_mc_delay #(
    parameter int unsigned D_W       = 32,
    parameter int unsigned CH        = 4,
    parameter int unsigned MAX_DEPTH = 16,
    localparam int unsigned DW_DEPTH = $clog2(MAX_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                shift_en,
    input  logic [CH*D_W-1:0]   data_in,
    input  logic                cfg_load,
    input  logic [DW_DEPTH-1:0] cfg_depth,
    output logic [CH*D_W-1:0]   data_out,
    output logic                out_valid,
    output logic [DW_DEPTH-1:0] depth_q
`ifdef SREG_MC_TAP_EN
    ,
    input  logic [DW_DEPTH-1:0] cfg_tap,
    output logic [DW_DEPTH-1:0] tap_q,
    output logic [CH*D_W-1:0]   tap_out,
    output logic                tap_valid
`endif
);

    localparam int unsigned BW = CH * D_W;
    localparam int unsigned PW = $clog2(MAX_DEPTH);
    localparam logic [DW_DEPTH-1:0] DEPTH_MAX = DW_DEPTH'(MAX_DEPTH);
    localparam logic [DW_DEPTH-1:0] ONE       = DW_DEPTH'(1);

    typedef enum logic {S_FILL, S_RUN} state_t;

    state_t              state, state_nxt;
    logic [PW-1:0]       wr_ptr, ptr_nxt;
    logic [DW_DEPTH-1:0] fill_cnt, fill_nxt;
    logic [DW_DEPTH-1:0] depth_nxt;
    logic [BW-1:0]       data_nxt;
    logic                valid_nxt;
    logic                wr_en;
    logic [BW-1:0]       rd_data;
    logic [BW-1:0]       mem [MAX_DEPTH];

    function automatic logic [DW_DEPTH-1:0] clamp_depth(input logic [DW_DEPTH-1:0] v);
        if (v == '0)
            return ONE;
        else if (v > DEPTH_MAX)
            return DEPTH_MAX;
        else
            return v;
    endfunction

    // Ring storage: async read, write-after-read on the same edge; not reset.
    assign rd_data = mem[wr_ptr];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= data_in;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FILL;
            wr_ptr    <= '0;
            fill_cnt  <= '0;
            depth_q   <= DEPTH_MAX;
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            wr_ptr    <= ptr_nxt;
            fill_cnt  <= fill_nxt;
            depth_q   <= depth_nxt;
            data_out  <= data_nxt;
            out_valid <= valid_nxt;
        end
    end

    // Next-state: a load flushes and wins over a simultaneous shift.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = wr_ptr;
        fill_nxt  = fill_cnt;
        depth_nxt = depth_q;
        data_nxt  = data_out;
        valid_nxt = out_valid;
        wr_en     = 1'b0;

        if (cfg_load) begin
            state_nxt = S_FILL;
            ptr_nxt   = '0;
            fill_nxt  = '0;
            depth_nxt = clamp_depth(cfg_depth);
            data_nxt  = '0;
            valid_nxt = 1'b0;
        end else if (shift_en) begin
            wr_en   = 1'b1;
            ptr_nxt = (DW_DEPTH'(wr_ptr) == depth_q - ONE) ? '0 : wr_ptr + PW'(1);
            case (state)
                S_FILL: begin
                    fill_nxt = fill_cnt + ONE;
                    data_nxt = '0;
                    if (fill_cnt == depth_q - ONE)
                        state_nxt = S_RUN;
                end
                S_RUN: begin
                    data_nxt  = rd_data;
                    valid_nxt = 1'b1;
                end
                default: state_nxt = S_FILL;
            endcase
        end
    end

`ifdef SREG_MC_TAP_EN
    logic [DW_DEPTH-1:0] tap_nxt;
    logic [DW_DEPTH-1:0] tap_cnt, tap_cnt_nxt;
    logic [DW_DEPTH-1:0] tap_addr;
    logic [DW_DEPTH-1:0] ld_depth;
    logic [BW-1:0]       tap_rd;
    logic [BW-1:0]       tap_out_nxt;
    logic                tap_valid_nxt;

    // Second read port at (wr_ptr - T) mod D; ordered so the sum never overflows.
    always_comb begin
        tap_addr = '0;
        if (DW_DEPTH'(wr_ptr) >= tap_q)
            tap_addr = DW_DEPTH'(wr_ptr) - tap_q;
        else
            tap_addr = DW_DEPTH'(wr_ptr) + (depth_q - tap_q);
    end

    assign tap_rd = mem[PW'(tap_addr)];

    always_ff @(posedge clk) begin
        if (rst) begin
            tap_q     <= ONE;
            tap_cnt   <= '0;
            tap_out   <= '0;
            tap_valid <= 1'b0;
        end else begin
            tap_q     <= tap_nxt;
            tap_cnt   <= tap_cnt_nxt;
            tap_out   <= tap_out_nxt;
            tap_valid <= tap_valid_nxt;
        end
    end

    // tap_cnt saturates at T; reaching it means k >= T for the current shift.
    always_comb begin
        tap_nxt       = tap_q;
        tap_cnt_nxt   = tap_cnt;
        tap_out_nxt   = tap_out;
        tap_valid_nxt = tap_valid;
        ld_depth      = clamp_depth(cfg_depth);

        if (cfg_load) begin
            if (cfg_tap == '0)
                tap_nxt = ONE;
            else if (cfg_tap > ld_depth)
                tap_nxt = ld_depth;
            else
                tap_nxt = cfg_tap;
            tap_cnt_nxt   = '0;
            tap_out_nxt   = '0;
            tap_valid_nxt = 1'b0;
        end else if (shift_en) begin
            if (tap_cnt == tap_q) begin
                tap_out_nxt   = tap_rd;
                tap_valid_nxt = 1'b1;
            end else begin
                tap_cnt_nxt = tap_cnt + ONE;
                tap_out_nxt = '0;
            end
        end
    end
`endif

endmodule
